// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    // ceil(w * log10(2)) using log10(2) ~= 0.30103 in fixed point
    function automatic int min_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= DIGIT_W'(5))
            dout = din + DIGIT_W'(3);
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle shift-add-3 binary-to-BCD converter with start/done handshake.
// Optional two's-complement input handling is enabled by defining BCD_SIGNED_EN.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [W-1:0]            bin,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                    ovf,
    output logic                    sign
);

    localparam int BW = DIGIT_W * DIGITS;
    localparam int CW = $clog2(W + 1);

    state_t          state, state_n;
    logic [W-1:0]    shreg;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   scratch_adj;
    logic [CW-1:0]   cnt;
    logic            ovf_sticky;
    logic [W-1:0]    load_val;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (scratch[g*DIGIT_W +: DIGIT_W]),
            .dout (scratch_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BCD_SIGNED_EN
    logic sign_lat;

    // Magnitude of a two's-complement word; the most negative value maps to 2^(W-1)
    always_comb begin
        load_val = bin;
        if (bin[W-1])
            load_val = ~bin + W'(1);
    end
`else
    always_comb load_val = bin;
    assign sign = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = CONV;
            CONV:    if (cnt == CW'(1)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            scratch    <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            ovf        <= 1'b0;
`ifdef BCD_SIGNED_EN
            sign_lat   <= 1'b0;
            sign       <= 1'b0;
`endif
        end else begin
            state <= state_n;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg      <= load_val;
                        scratch    <= '0;
                        cnt        <= CW'(W);
                        ovf_sticky <= 1'b0;
`ifdef BCD_SIGNED_EN
                        sign_lat   <= bin[W-1];
`endif
                    end
                end
                CONV: begin
                    // Top bit of the adjusted scratch is lost by the shift; remember it
                    {scratch, shreg} <= {scratch_adj[BW-2:0], shreg, 1'b0};
                    ovf_sticky       <= ovf_sticky | scratch_adj[BW-1];
                    cnt              <= cnt - CW'(1);
                end
                DONE: begin
                    bcd  <= scratch;
                    ovf  <= ovf_sticky;
                    done <= 1'b1;
`ifdef BCD_SIGNED_EN
                    sign <= sign_lat;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter (3-digit and 2-digit instances).
module tb_bcd_seq_converter;
    import bcd_pkg::*;

    localparam int W  = 8;
    localparam int D3 = min_digits(W);
    localparam int D2 = 2;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic            rst = 1'b1;
    logic            start_a = 1'b0, start_b = 1'b0;
    logic [W-1:0]    bin_a = '0, bin_b = '0;
    logic            busy_a, done_a, ovf_a, sign_a;
    logic            busy_b, done_b, ovf_b, sign_b;
    logic [4*D3-1:0] bcd_a;
    logic [4*D2-1:0] bcd_b;

    bcd_seq_converter #(.W(W), .DIGITS(D3)) u_dut_a (
        .clk(CLOCK_50), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a), .sign(sign_a)
    );

    bcd_seq_converter #(.W(W), .DIGITS(D2)) u_dut_b (
        .clk(CLOCK_50), .rst(rst), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b), .sign(sign_b)
    );

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        logic        sign;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference: plain decimal arithmetic on the (possibly signed) input value
    function automatic exp_t model(input logic [W-1:0] b, input int digits);
        exp_t        e;
        int unsigned mag;
        mag    = 32'(b);
        e.sign = 1'b0;
        e.bcd  = '0;
`ifdef BCD_SIGNED_EN
        if (b[W-1]) begin
            mag    = 32'd256 - 32'(b);
            e.sign = 1'b1;
        end
`endif
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        e.ovf = (mag != 0);
        return e;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? done_b : done_a;
    endfunction
    function automatic logic cur_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction
    function automatic logic [11:0] cur_bcd(input bit sel);
        return sel ? 12'(bcd_b) : 12'(bcd_a);
    endfunction
    function automatic logic cur_ovf(input bit sel);
        return sel ? ovf_b : ovf_a;
    endfunction
    function automatic logic cur_sign(input bit sel);
        return sel ? sign_b : sign_a;
    endfunction

    // Called while the DUT is idle, away from a clock edge
    task automatic launch(input bit sel, input logic [W-1:0] v, input bit hold);
        if (sel) begin bin_b = v; start_b = 1'b1; end
        else     begin bin_a = v; start_a = 1'b1; end
        @(posedge CLOCK_50); #1;
        sb.push_back(model(v, sel ? D2 : D3));
        tests++;
        if (cur_busy(sel) !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_accept v=%0d: got %b want 1", v, cur_busy(sel));
        end
        if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
    endtask

    // n0 = edges already elapsed since the accepting edge
    task automatic collect(input bit sel, input int n0, input string name);
        int   n;
        exp_t e;
        n = n0;
        while (cur_done(sel) !== 1'b1 && n < 40) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        tests++;
        if (n != W + 1) begin
            fails++;
            $display("FAIL latency_%s: got %0d edges want %0d", name, n, W + 1);
        end
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_%s: got empty queue want one entry", name);
        end else begin
            e = sb.pop_front();
            tests++;
            if (cur_bcd(sel) !== e.bcd) begin
                fails++;
                $display("FAIL bcd_%s: got %h want %h", name, cur_bcd(sel), e.bcd);
            end
            tests++;
            if (cur_ovf(sel) !== e.ovf) begin
                fails++;
                $display("FAIL ovf_%s: got %b want %b", name, cur_ovf(sel), e.ovf);
            end
            tests++;
            if (cur_sign(sel) !== e.sign) begin
                fails++;
                $display("FAIL sign_%s: got %b want %b", name, cur_sign(sel), e.sign);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        tests++;
        if ({busy_a, done_a, bcd_a, ovf_a, sign_a} !== '0) begin
            fails++;
            $display("FAIL reset_a: got %b%b %h %b%b want all zero", busy_a, done_a, bcd_a, ovf_a, sign_a);
        end
        tests++;
        if ({busy_b, done_b, bcd_b, ovf_b, sign_b} !== '0) begin
            fails++;
            $display("FAIL reset_b: got %b%b %h %b%b want all zero", busy_b, done_b, bcd_b, ovf_b, sign_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        launch(1'b0, 8'd255, 1'b0);
        collect(1'b0, 0, "255");
        @(posedge CLOCK_50); #1;
        tests++;
        if (done_a !== 1'b0) begin
            fails++;
            $display("FAIL done_single_pulse: got %b want 0", done_a);
        end
    endtask

    task automatic test_zero_then_held;
        launch(1'b0, 8'd0, 1'b0);
        collect(1'b0, 0, "zero");
        launch(1'b0, 8'd9, 1'b1);
        collect(1'b0, 0, "held");
        start_a = 1'b0;
        @(posedge CLOCK_50); #1;
        tests++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            fails++;
            $display("FAIL held_no_restart: got busy=%b done=%b want 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_ignore_busy;
        bit bad;
        launch(1'b0, 8'd100, 1'b0);
        repeat (2) @(posedge CLOCK_50);
        #1;
        bin_a = 8'd7; start_a = 1'b1;
        @(posedge CLOCK_50); #1;
        start_a = 1'b0;
        repeat (5) @(posedge CLOCK_50);
        #1;
        start_a = 1'b1;           // lands in the DONE cycle
        collect(1'b0, 8, "ignore");
        start_a = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLOCK_50); #1;
            if (done_a !== 1'b0 || busy_a !== 1'b0 || bcd_a !== 12'h100) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL ignore_quiet: got done=%b busy=%b bcd=%h want 0 0 100", done_a, busy_a, bcd_a);
        end
    endtask

    task automatic test_reset_mid;
        bit bad;
        launch(1'b0, 8'd200, 1'b0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        rst = 1'b1;
        @(posedge CLOCK_50); #1;
        tests++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || bcd_a !== '0 || ovf_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b bcd=%h ovf=%b want 0 0 000 0", busy_a, done_a, bcd_a, ovf_a);
        end
        rst = 1'b0;
        sb.delete();
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLOCK_50); #1;
            if (done_a !== 1'b0 || busy_a !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL reset_no_late_done: got done=%b busy=%b want 0 0", done_a, busy_a);
        end
        launch(1'b0, 8'd42, 1'b0);
        collect(1'b0, 0, "after_reset");
    endtask

    task automatic test_overflow;
        launch(1'b1, 8'd200, 1'b0);
        collect(1'b1, 0, "ovf200");
        launch(1'b1, 8'd99, 1'b0);
        collect(1'b1, 0, "ovf99");
        launch(1'b1, 8'd100, 1'b0);
        collect(1'b1, 0, "ovf100");
    endtask

`ifdef BCD_SIGNED_EN
    task automatic test_signed;
        launch(1'b0, 8'hF6, 1'b0);
        collect(1'b0, 0, "neg10");
        launch(1'b0, 8'h80, 1'b0);
        collect(1'b0, 0, "neg128");
        launch(1'b0, 8'h05, 1'b0);
        collect(1'b0, 0, "pos5");
    endtask
`endif

    task automatic test_back_to_back;
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) begin
            v = (i < 3) ? W'(127 + i) : W'($urandom_range(0, 255));
            launch(1'b0, v, 1'b0);
            collect(1'b0, 0, "b2b");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_then_held();
        test_ignore_busy();
        test_reset_mid();
        test_overflow();
`ifdef BCD_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
Multi-cycle binary-to-BCD converter using the shift-add-3 (double dabble) method. It sits directly downstream of the ALU result multiplexer and upstream of the seven_segment_driver instances. It takes one result word per start request and produces packed BCD digits plus a one-cycle done pulse. It is the sequential, handshaked counterpart of the combinational converter, and is sized for wider ALU results.

Parameters:
W, 8, binary input width in bits (must be >= 1)
DIGITS, 3, number of 4-bit BCD output digits (DIGITS*4 >= 4)

Ports:
clk  input  1  system clock (CLOCK_50 at top level)
rst  input  1  synchronous active-high reset
start  input  1  conversion request; sampled only in IDLE
bin  input  W  binary value; captured on the edge that accepts start
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse; bcd, ovf and sign are valid from this cycle
bcd  output  4*DIGITS  packed result; digit 0 (units) in bits [3:0]; held until the next done
ovf  output  1  result needed more than DIGITS digits; held with bcd
sign  output  1  result negative (only with BCD_SIGNED_EN; otherwise tied 0)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset (rst high at a posedge), regardless of state:
  - state goes to IDLE.
  - busy=0, done=0, bcd=0, ovf=0, sign=0.
  - Internal shift and scratch registers are cleared.
- Reset mid-conversion aborts the conversion. No done is produced, and the outputs show zeros.
- States are IDLE, CONV and DONE.
- IDLE:
  - If start=1 at a posedge, capture bin into the shift register and clear the BCD scratch register.
  - Load the bit counter with W and go to CONV.
  - If start=0, stay in IDLE.
- CONV, one bit per cycle:
  - For every scratch digit >= 5, add 3 to that digit. Use a 4-bit add with no carry between digits.
  - Shift the {scratch, shift} register left by 1.
  - Any 1 shifted out of the top scratch digit sets a sticky overflow flag.
  - Decrement the counter. When the counter reaches 0, go to DONE.
- DONE (exactly one cycle):
  - Transfer scratch to bcd and the sticky flag to ovf, both registered.
  - done=1. Next state is IDLE.
- Latency: done is high in the cycle after the W+1st posedge following the accepting edge. Throughput is one conversion per W+2 cycles.
- start while busy=1, including during DONE, is ignored and not queued.
- bin changes after the accepting edge have no effect on the conversion in flight.
- done is never high for two consecutive cycles.
- bcd, ovf and sign change only together with done (or on reset).
- bin=0 gives bcd=0, ovf=0.
- When DIGITS is too small, the low digits are still correct modulo 10^DIGITS and ovf=1.

Optional Feature:
Macro: BCD_SIGNED_EN
- Defined:
  - bin is treated as two's complement.
  - On the accepting edge, capture |bin| (bitwise invert plus 1 when bin[W-1]=1) and latch sign=bin[W-1]. sign is published at done.
  - The most negative value 2^(W-1) converts to its correct magnitude, with sign=1.
- Not defined:
  - bin is unsigned and sign is tied 0.
  - No negation logic is synthesised.

Decomposition:
- Shared package bcd_pkg contains:
  - the state enum (IDLE, CONV, DONE);
  - localparam DIGIT_W=4;
  - function min_digits(W), which returns ceil(W*log10 2). The bench uses it to choose DIGITS.
- One sub-module: bcd_digit_adjust. It is combinational, with a 4-bit input and a 4-bit output (in >= 5 ? in+3 : in), and is instantiated DIGITS times inside CONV.

Test Plan:
1. W=8, DIGITS=3; bin=8'd255, start pulsed one cycle -> busy rises the next cycle; done pulses exactly once W+1=9 edges after acceptance; bcd=12'h255, ovf=0.
2. W=8, DIGITS=3; bin=0 -> bcd=12'h000, ovf=0. Then immediately bin=8'd9 with start held high through the whole conversion -> the second conversion starts only on the first edge back in IDLE, and the result is bcd=12'h009.
3. Start ignored while busy: accept bin=8'd100; pulse start with bin=8'd7 during CONV and again during DONE -> a single done with bcd=12'h100; no second done follows unless start is asserted in IDLE.
4. Reset mid-operation: accept bin=8'd200, assert rst on the 4th CONV cycle -> the next cycle shows busy=0, bcd=0, done=0 and no late done pulse; a fresh start with bin=8'd42 then gives bcd=12'h042.
5. Overflow: W=8, DIGITS=2, bin=8'd200 -> bcd=8'h00, ovf=1; with bin=8'd99 -> bcd=8'h99, ovf=0.
6. BCD_SIGNED_EN, W=8, DIGITS=3:
   - bin=8'hF6 -> bcd=12'h010, sign=1.
   - bin=8'h80 -> bcd=12'h128, sign=1.
   - bin=8'h05 -> bcd=12'h005, sign=0.
